// File: rtl/e203_exu_longp_wbuf.sv
// In-order write-back buffer for long-pipe results (LSU, MUL/DIV), released in OITF retire order.
// Latency: 1 cycle from accept to write-back; 0 cycles when E203_LONGP_WBUF_BYPASS_EN is defined and the result is the head.
// Backpressure: a producer sees ready=0 while its tag's slot is full; a stalled head holds its payload until the outlet is ready.
module e203_exu_longp_wbuf #(
  parameter int ITAG_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              lsu_wbck_i_valid,
  output logic              lsu_wbck_i_ready,
  input  logic [31:0]       lsu_wbck_i_wdat,
  input  logic [ITAG_W-1:0] lsu_wbck_i_itag,
  input  logic              lsu_wbck_i_err,

  input  logic              mdv_wbck_i_valid,
  output logic              mdv_wbck_i_ready,
  input  logic [31:0]       mdv_wbck_i_wdat,
  input  logic [ITAG_W-1:0] mdv_wbck_i_itag,
  input  logic              mdv_wbck_i_err,

  input  logic              oitf_empty,
  input  logic [ITAG_W-1:0] oitf_ret_ptr,
  input  logic [4:0]        oitf_ret_rdidx,
  input  logic              oitf_ret_rdwen,
  input  logic              oitf_ret_rdfpu,
  output logic              oitf_ret_ena,

  output logic              longp_wbck_o_valid,
  input  logic              longp_wbck_o_ready,
  output logic [31:0]       longp_wbck_o_wdat,
  output logic [4:0]        longp_wbck_o_flags,
  output logic [4:0]        longp_wbck_o_rdidx,
  output logic              longp_wbck_o_rdfpu,

  output logic              longp_excp_o_valid,
  input  logic              longp_excp_o_ready
);

  localparam int XLEN  = 32;
  localparam int NSLOT = 1 << ITAG_W;

  // Per-slot state, indexed by instruction tag. rdidx/rdfpu come from the OITF at retire.
  logic [NSLOT-1:0] vld;
  logic [NSLOT-1:0] err;
  logic [XLEN-1:0]  wdat_q [NSLOT];

  logic            lsu_acc, mdv_acc;
  logic            lsu_byp, mdv_byp;
  logic            stor_go;
  logic            head_go;
  logic            head_err;
  logic [XLEN-1:0] head_dat;
  logic            stor_ret;

  // Whether the outlet a head of the given error class would use can take it now.
  function automatic logic outlet_rdy(input logic is_err);
    if (is_err)              return longp_excp_o_ready;
    else if (oitf_ret_rdwen) return longp_wbck_o_ready;
    else                     return 1'b1;
  endfunction

  // Accept rule uses registered vld only, so a slot freed this cycle refills next cycle at the earliest.
  // On a same-tag collision the LSU wins.
  always_comb begin
    lsu_wbck_i_ready = ~vld[lsu_wbck_i_itag];
    mdv_wbck_i_ready = ~vld[mdv_wbck_i_itag]
                     & ~(lsu_wbck_i_valid & (lsu_wbck_i_itag == mdv_wbck_i_itag));
    lsu_acc = lsu_wbck_i_valid & lsu_wbck_i_ready;
    mdv_acc = mdv_wbck_i_valid & mdv_wbck_i_ready;
  end

`ifdef E203_LONGP_WBUF_BYPASS_EN
  // An arriving result matching an empty head slot retires straight through; LSU has priority.
  always_comb begin
    lsu_byp = lsu_acc & (lsu_wbck_i_itag == oitf_ret_ptr) & ~vld[oitf_ret_ptr]
            & ~oitf_empty & outlet_rdy(lsu_wbck_i_err);
    mdv_byp = mdv_acc & (mdv_wbck_i_itag == oitf_ret_ptr) & ~vld[oitf_ret_ptr]
            & ~oitf_empty & outlet_rdy(mdv_wbck_i_err) & ~lsu_byp;
  end
`else
  // Every result is registered first.
  always_comb begin
    lsu_byp = 1'b0;
    mdv_byp = 1'b0;
  end
`endif

  // Head selection: a bypassing result, otherwise the stored slot at the retire pointer.
  always_comb begin
    stor_go  = vld[oitf_ret_ptr] & ~oitf_empty;
    head_go  = stor_go | lsu_byp | mdv_byp;
    head_err = err[oitf_ret_ptr];
    head_dat = wdat_q[oitf_ret_ptr];
    if (lsu_byp) begin
      head_err = lsu_wbck_i_err;
      head_dat = lsu_wbck_i_wdat;
    end else if (mdv_byp) begin
      head_err = mdv_wbck_i_err;
      head_dat = mdv_wbck_i_wdat;
    end
  end

  // Outlet steering and retire pulse; payload is forced to zero whenever write-back is not valid.
  always_comb begin
    longp_wbck_o_valid = head_go & ~head_err & oitf_ret_rdwen;
    longp_excp_o_valid = head_go & head_err;
    oitf_ret_ena       = head_go & outlet_rdy(head_err);
    longp_wbck_o_flags = 5'b0;
    longp_wbck_o_wdat  = longp_wbck_o_valid ? head_dat       : '0;
    longp_wbck_o_rdidx = longp_wbck_o_valid ? oitf_ret_rdidx : '0;
    longp_wbck_o_rdfpu = longp_wbck_o_valid & oitf_ret_rdfpu;
    stor_ret           = oitf_ret_ena & stor_go & ~lsu_byp & ~mdv_byp;
  end

  // Slot valid/error bookkeeping: set on a registered accept, clear on retire of the stored head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      err <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (stor_ret && (oitf_ret_ptr == ITAG_W'(i))) vld[i] <= 1'b0;
        if (lsu_acc && !lsu_byp && (lsu_wbck_i_itag == ITAG_W'(i))) begin
          vld[i] <= 1'b1;
          err[i] <= lsu_wbck_i_err;
        end
        if (mdv_acc && !mdv_byp && (mdv_wbck_i_itag == ITAG_W'(i))) begin
          vld[i] <= 1'b1;
          err[i] <= mdv_wbck_i_err;
        end
      end
    end
  end

  // Result data capture; left unreset because outputs are masked while no slot is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSLOT; i++) begin
      if (lsu_acc && !lsu_byp && (lsu_wbck_i_itag == ITAG_W'(i))) wdat_q[i] <= lsu_wbck_i_wdat;
      if (mdv_acc && !mdv_byp && (mdv_wbck_i_itag == ITAG_W'(i))) wdat_q[i] <= mdv_wbck_i_wdat;
    end
  end

  // Two producers never complete the same tag in one cycle.
  a_tag_clash: assert property (@(posedge clk) disable iff (!rst_n)
    !(lsu_wbck_i_valid && mdv_wbck_i_valid && (lsu_wbck_i_itag == mdv_wbck_i_itag)));

  // A buffered head implies an outstanding OITF entry.
  a_head_without_oitf: assert property (@(posedge clk) disable iff (!rst_n)
    !(vld[oitf_ret_ptr] && oitf_empty));

endmodule

// File: tb/tb_e203_exu_longp_wbuf.sv
// Directed bench for e203_exu_longp_wbuf in its default (registered, non-bypass) build.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_e203_exu_longp_wbuf;

  logic        clk;
  logic        rst_n;
  logic        lsu_wbck_i_valid, lsu_wbck_i_ready, lsu_wbck_i_err;
  logic [31:0] lsu_wbck_i_wdat;
  logic [0:0]  lsu_wbck_i_itag;
  logic        mdv_wbck_i_valid, mdv_wbck_i_ready, mdv_wbck_i_err;
  logic [31:0] mdv_wbck_i_wdat;
  logic [0:0]  mdv_wbck_i_itag;
  logic        oitf_empty;
  logic [0:0]  oitf_ret_ptr;
  logic [4:0]  oitf_ret_rdidx;
  logic        oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena;
  logic        longp_wbck_o_valid, longp_wbck_o_ready;
  logic [31:0] longp_wbck_o_wdat;
  logic [4:0]  longp_wbck_o_flags, longp_wbck_o_rdidx;
  logic        longp_wbck_o_rdfpu;
  logic        longp_excp_o_valid, longp_excp_o_ready;

  int n_chk  = 0;
  int n_fail = 0;

  e203_exu_longp_wbuf #(.ITAG_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_wbck_i_valid(lsu_wbck_i_valid), .lsu_wbck_i_ready(lsu_wbck_i_ready),
    .lsu_wbck_i_wdat(lsu_wbck_i_wdat), .lsu_wbck_i_itag(lsu_wbck_i_itag), .lsu_wbck_i_err(lsu_wbck_i_err),
    .mdv_wbck_i_valid(mdv_wbck_i_valid), .mdv_wbck_i_ready(mdv_wbck_i_ready),
    .mdv_wbck_i_wdat(mdv_wbck_i_wdat), .mdv_wbck_i_itag(mdv_wbck_i_itag), .mdv_wbck_i_err(mdv_wbck_i_err),
    .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
    .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu), .oitf_ret_ena(oitf_ret_ena),
    .longp_wbck_o_valid(longp_wbck_o_valid), .longp_wbck_o_ready(longp_wbck_o_ready),
    .longp_wbck_o_wdat(longp_wbck_o_wdat), .longp_wbck_o_flags(longp_wbck_o_flags),
    .longp_wbck_o_rdidx(longp_wbck_o_rdidx), .longp_wbck_o_rdfpu(longp_wbck_o_rdfpu),
    .longp_excp_o_valid(longp_excp_o_valid), .longp_excp_o_ready(longp_excp_o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_wbck_i_valid = 0; lsu_wbck_i_err = 0; lsu_wbck_i_itag = 0; lsu_wbck_i_wdat = 0;
    mdv_wbck_i_valid = 0; mdv_wbck_i_err = 0; mdv_wbck_i_itag = 0; mdv_wbck_i_wdat = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    oitf_empty = 1; oitf_ret_ptr = 0; oitf_ret_rdidx = 5; oitf_ret_rdwen = 1; oitf_ret_rdfpu = 1;
    longp_wbck_o_ready = 1; longp_excp_o_ready = 1;
    #2;
    n_chk++; if (lsu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lsu_ready got %b want 1", lsu_wbck_i_ready); end
    n_chk++; if (mdv_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mdv_ready got %b want 1", mdv_wbck_i_ready); end
    n_chk++; if (oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL rst_ret_ena got %b want 0", oitf_ret_ena); end
    n_chk++; if (longp_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wbck_valid got %b want 0", longp_wbck_o_valid); end
    n_chk++; if (longp_excp_o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_excp_valid got %b want 0", longp_excp_o_valid); end
    n_chk++; if ({longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_wbck_o_rdfpu, longp_wbck_o_flags} !== 43'd0) begin
      n_fail++; $display("FAIL rst_payload got wdat=%h rdidx=%0d rdfpu=%b flags=%h want all 0",
                         longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_wbck_o_rdfpu, longp_wbck_o_flags);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = 5; oitf_ret_rdwen = 1; oitf_ret_rdfpu = 0;
    lsu_wbck_i_valid = 1; lsu_wbck_i_itag = 0; lsu_wbck_i_wdat = 32'h1234_5678;
    #1;
    n_chk++; if (lsu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accept got %b want 1", lsu_wbck_i_ready); end
    n_chk++; if (longp_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_wb_n got %b want 0", longp_wbck_o_valid); end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (longp_wbck_o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", longp_wbck_o_valid); end
    n_chk++; if (longp_wbck_o_wdat !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_wdat got %h want 12345678", longp_wbck_o_wdat); end
    n_chk++; if (longp_wbck_o_rdidx !== 5'd5) begin n_fail++; $display("FAIL basic_rdidx got %0d want 5", longp_wbck_o_rdidx); end
    n_chk++; if (longp_wbck_o_flags !== 5'd0) begin n_fail++; $display("FAIL basic_flags got %h want 0", longp_wbck_o_flags); end
    n_chk++; if (oitf_ret_ena !== 1'b1) begin n_fail++; $display("FAIL basic_ret_ena got %b want 1", oitf_ret_ena); end
    tick();
    oitf_ret_ptr = 1; oitf_empty = 1;
    #1;
    n_chk++; if (longp_wbck_o_valid !== 1'b0 || oitf_ret_ena !== 1'b0) begin
      n_fail++; $display("FAIL basic_single_pulse got valid=%b ret=%b want 0 0", longp_wbck_o_valid, oitf_ret_ena);
    end
  endtask

  task automatic test_out_of_order();
    // Cycle 0 here: instructions tag0, tag1 outstanding; tag1 (MDV) finishes at 2, tag0 (LSU) at 5.
    oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = 3; oitf_ret_rdwen = 1;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      tick();
      idle_inputs();
      if (cyc == 2) begin mdv_wbck_i_valid = 1; mdv_wbck_i_itag = 1; mdv_wbck_i_wdat = 32'hAAAA_0001; end
      if (cyc == 5) begin lsu_wbck_i_valid = 1; lsu_wbck_i_itag = 0; lsu_wbck_i_wdat = 32'hBBBB_0000; end
      if (cyc == 7) begin oitf_ret_ptr = 1; oitf_ret_rdidx = 7; end
      #1;
      if (cyc < 6) begin
        n_chk++; if (longp_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early_wb cyc=%0d got %b want 0", cyc, longp_wbck_o_valid); end
      end
      if (cyc == 4) begin
        mdv_wbck_i_itag = 1; #1;
        n_chk++; if (mdv_wbck_i_ready !== 1'b0) begin n_fail++; $display("FAIL ooo_slot1_full got %b want 0", mdv_wbck_i_ready); end
      end
      if (cyc == 6) begin
        n_chk++; if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_wdat !== 32'hBBBB_0000 || oitf_ret_ena !== 1'b1) begin
          n_fail++; $display("FAIL ooo_tag0 got v=%b d=%h r=%b want 1 bbbb0000 1", longp_wbck_o_valid, longp_wbck_o_wdat, oitf_ret_ena);
        end
      end
      if (cyc == 7) begin
        n_chk++; if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_wdat !== 32'hAAAA_0001 ||
                     longp_wbck_o_rdidx !== 5'd7 || oitf_ret_ena !== 1'b1) begin
          n_fail++; $display("FAIL ooo_tag1 got v=%b d=%h rd=%0d r=%b want 1 aaaa0001 7 1",
                             longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx, oitf_ret_ena);
        end
      end
    end
    tick();
    oitf_ret_ptr = 0; oitf_empty = 1;
  endtask

  task automatic test_exception();
    oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdwen = 1; longp_excp_o_ready = 0;
    lsu_wbck_i_valid = 1; lsu_wbck_i_itag = 0; lsu_wbck_i_err = 1; lsu_wbck_i_wdat = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (longp_excp_o_valid !== 1'b1 || longp_wbck_o_valid !== 1'b0 || oitf_ret_ena !== 1'b0) begin
        n_fail++; $display("FAIL excp_hold k=%0d got ev=%b wv=%b r=%b want 1 0 0", k, longp_excp_o_valid, longp_wbck_o_valid, oitf_ret_ena);
      end
      tick();
    end
    longp_excp_o_ready = 1;
    #1;
    n_chk++; if (longp_excp_o_valid !== 1'b1 || longp_wbck_o_valid !== 1'b0 || oitf_ret_ena !== 1'b1) begin
      n_fail++; $display("FAIL excp_retire got ev=%b wv=%b r=%b want 1 0 1", longp_excp_o_valid, longp_wbck_o_valid, oitf_ret_ena);
    end
    tick();
    #1;
    n_chk++; if (longp_excp_o_valid !== 1'b0 || oitf_ret_ena !== 1'b0) begin
      n_fail++; $display("FAIL excp_cleared got ev=%b r=%b want 0 0", longp_excp_o_valid, oitf_ret_ena);
    end
    oitf_empty = 1;
  endtask

  task automatic test_back_to_back();
    oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = 9; oitf_ret_rdwen = 1; longp_wbck_o_ready = 0;
    lsu_wbck_i_valid = 1; lsu_wbck_i_itag = 0; lsu_wbck_i_wdat = 32'h0000_0011;
    mdv_wbck_i_valid = 1; mdv_wbck_i_itag = 1; mdv_wbck_i_wdat = 32'h0000_0022;
    tick();
    lsu_wbck_i_valid = 0; mdv_wbck_i_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if (lsu_wbck_i_ready !== 1'b0 || mdv_wbck_i_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_full_ready k=%0d got lsu=%b mdv=%b want 0 0", k, lsu_wbck_i_ready, mdv_wbck_i_ready);
      end
      n_chk++; if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_wdat !== 32'h11 || oitf_ret_ena !== 1'b0) begin
        n_fail++; $display("FAIL bp_stable k=%0d got v=%b d=%h r=%b want 1 11 0", k, longp_wbck_o_valid, longp_wbck_o_wdat, oitf_ret_ena);
      end
      tick();
    end
    longp_wbck_o_ready = 1;
    #1;
    n_chk++; if (oitf_ret_ena !== 1'b1 || longp_wbck_o_wdat !== 32'h11) begin
      n_fail++; $display("FAIL bp_first got r=%b d=%h want 1 11", oitf_ret_ena, longp_wbck_o_wdat);
    end
    tick();
    oitf_ret_ptr = 1;
    #1;
    n_chk++; if (oitf_ret_ena !== 1'b1 || longp_wbck_o_wdat !== 32'h22) begin
      n_fail++; $display("FAIL bp_second got r=%b d=%h want 1 22", oitf_ret_ena, longp_wbck_o_wdat);
    end
    n_chk++; if (lsu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_slot0_freed got %b want 1", lsu_wbck_i_ready); end
    tick();
    oitf_ret_ptr = 0; oitf_empty = 1;
  endtask

  task automatic test_no_rdwen();
    oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdwen = 0; longp_wbck_o_ready = 0;
    mdv_wbck_i_valid = 1; mdv_wbck_i_itag = 0; mdv_wbck_i_wdat = 32'h5555_AAAA;
    tick();
    idle_inputs();
    #1;
    n_chk++; if (oitf_ret_ena !== 1'b1 || longp_wbck_o_valid !== 1'b0 || longp_excp_o_valid !== 1'b0 || longp_wbck_o_wdat !== 32'd0) begin
      n_fail++; $display("FAIL nowen_retire got r=%b wv=%b ev=%b d=%h want 1 0 0 0",
                         oitf_ret_ena, longp_wbck_o_valid, longp_excp_o_valid, longp_wbck_o_wdat);
    end
    tick();
    #1;
    n_chk++; if (oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL nowen_once got %b want 0", oitf_ret_ena); end
    oitf_empty = 1; oitf_ret_rdwen = 1; longp_wbck_o_ready = 1;
  endtask

  task automatic test_reset_midrun();
    oitf_empty = 0; oitf_ret_ptr = 1; oitf_ret_rdidx = 4; oitf_ret_rdwen = 1; longp_wbck_o_ready = 0;
    lsu_wbck_i_valid = 1; lsu_wbck_i_itag = 1; lsu_wbck_i_wdat = 32'h0000_0055;
    tick();
    idle_inputs();
    #1;
    n_chk++; if (longp_wbck_o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_stalled got %b want 1", longp_wbck_o_valid); end
    rst_n = 0;
    #1;
    n_chk++; if (longp_wbck_o_valid !== 1'b0 || longp_wbck_o_wdat !== 32'd0 || longp_wbck_o_rdidx !== 5'd0 || oitf_ret_ena !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_clear got v=%b d=%h rd=%0d r=%b want 0 0 0 0",
                         longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx, oitf_ret_ena);
    end
    n_chk++; if (lsu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", lsu_wbck_i_ready); end
    #2;
    rst_n = 1;
    longp_wbck_o_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      n_chk++; if (longp_wbck_o_valid !== 1'b0 || oitf_ret_ena !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_stale k=%0d got v=%b r=%b want 0 0", k, longp_wbck_o_valid, oitf_ret_ena);
      end
    end
    oitf_empty = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_exception();
    test_back_to_back();
    test_no_rdwen();
    test_reset_midrun();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/e203_exu_longp_wbuf.md
# e203_exu_longp_wbuf

In-order write-back buffer for long-pipeline results: collects completions from the LSU and the MUL/DIV unit, which may finish out of order, and releases them in program order. Order is set by the OITF retire pointer. The block sits directly upstream of the write-back arbiter and drives its long-pipe port (`longp_wbck_*`). Results flagged with an error go to the commit/exception path instead of the regfile.

## Interface
Parameters:
- `ITAG_W`, default 1: instruction-tag width; buffer has `2**ITAG_W` slots (matches OITF depth).

Ports (`XLEN` = `E203_XLEN` = 32, `RFW` = `E203_RFIDX_WIDTH` = 5):
- `clk` input 1: clock; single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `lsu_wbck_i_valid` / `lsu_wbck_i_ready` in / out, 1 each: LSU result handshake.
- `lsu_wbck_i_wdat` in XLEN: LSU result data.
- `lsu_wbck_i_itag` in ITAG_W: LSU result tag.
- `lsu_wbck_i_err` in 1: LSU error flag.
- `mdv_wbck_i_valid` / `mdv_wbck_i_ready` in / out, 1 each: MUL/DIV result handshake.
- `mdv_wbck_i_wdat` in XLEN: MUL/DIV result data.
- `mdv_wbck_i_itag` in ITAG_W: MUL/DIV result tag.
- `mdv_wbck_i_err` in 1: MUL/DIV error flag.
- `oitf_empty` in 1: no outstanding long-pipe instruction.
- `oitf_ret_ptr` in ITAG_W: tag of the oldest outstanding instruction.
- `oitf_ret_rdidx` in RFW: destination register of the oldest entry.
- `oitf_ret_rdwen` in 1: oldest entry writes a register.
- `oitf_ret_rdfpu` in 1: destination is in the FPU register file.
- `oitf_ret_ena` out 1: one-cycle pulse; pops the OITF entry.
- `longp_wbck_o_valid` / `longp_wbck_o_ready` out / in, 1 each: write-back handshake to the arbiter.
- `longp_wbck_o_wdat` out XLEN: write-back data.
- `longp_wbck_o_flags` out 5: always 5'b0.
- `longp_wbck_o_rdidx` out RFW: destination register.
- `longp_wbck_o_rdfpu` out 1: FPU-destination flag.
- `longp_excp_o_valid` / `longp_excp_o_ready` out / in, 1 each: error report handshake.

## Operation
- Per slot state: `vld`, `err`, `wdat[XLEN]`, indexed by tag. `rdidx` and `rdfpu` are not stored; they are taken from the OITF at retire.
- Accept rule for each source: `ready = ~vld[itag]`, using registered `vld`.
  - Each accepted result writes its slot at the clock edge.
  - LSU and MDV with different tags may both be accepted in the same cycle.
  - Same tag from both sources in one cycle is illegal: LSU wins, `mdv_wbck_i_ready` = 0, assertion fires.
- Head is `slot[oitf_ret_ptr]`. `head_go = vld[oitf_ret_ptr] & ~oitf_empty`.
- With `head_go`, exactly one case applies:
  - err=0 & rdwen=1: `longp_wbck_o_valid` = 1 with head data, `oitf_ret_rdidx`, `oitf_ret_rdfpu`. Retire on `longp_wbck_o_ready`.
  - err=0 & rdwen=0: retire immediately. No write-back valid, no exception valid.
  - err=1: `longp_excp_o_valid` = 1, `longp_wbck_o_valid` = 0. Retire on `longp_excp_o_ready`.
- Retire:
  - `oitf_ret_ena` = 1 for that cycle.
  - Head `vld` clears at the edge.
  - At most one retire per cycle.
- A slot freed this cycle cannot be refilled in the same cycle, because ready uses registered `vld`.
- Head valid while `oitf_empty` = 1 is illegal: assertion fires, nothing retires, state holds.

## Timing
- Reset: all `vld` = 0.
  - `lsu_wbck_i_ready` = `mdv_wbck_i_ready` = 1.
  - `oitf_ret_ena`, `longp_wbck_o_valid`, `longp_excp_o_valid` = 0.
  - `longp_wbck_o_wdat`, `longp_wbck_o_rdidx`, `longp_wbck_o_rdfpu`, `longp_wbck_o_flags` = 0.
  - Data registers need not be reset, but outputs are masked to 0 when not valid.
- Latency: result accepted in cycle N, head in order, downstream ready → `longp_wbck_o_valid` in cycle N+1, `oitf_ret_ena` in N+1.
- Out-of-order completion: the younger result waits in its slot until the older one retires. It is presented in the cycle after the older retire.
- Backpressure:
  - `longp_wbck_o_valid` holds, with stable payload, until `longp_wbck_o_ready`.
  - The exception port behaves the same way.
  - Producers whose slot is full see ready = 0.
- Throughput: one retire per cycle when results are already buffered.
- Reset asserted mid-operation drops all buffered results; outputs return to reset values asynchronously.

## Configuration
- `E203_LONGP_WBUF_BYPASS_EN` defined: an arriving result becomes the head in the same cycle if all of these hold:
  - its tag equals `oitf_ret_ptr`;
  - the slot is empty and `oitf_empty` = 0;
  - its outlet is ready (or rdwen = 0).
  - Then it is retired combinationally, with 0-cycle latency, and not written into the slot.
  - If both sources qualify, only LSU bypasses.
- Undefined: every result is registered first; minimum latency is 1 cycle.

## Test plan
- Reset, then LSU tag0 wdat=0x1234_5678, rdidx=5 → next cycle `longp_wbck_o_valid` = 1, wdat=0x12345678, rdidx=5, flags=0, `oitf_ret_ena` pulse; with BYPASS_EN this occurs in the same cycle.
- MDV tag1 completes at cycle 2, LSU tag0 at cycle 5, ret_ptr=0 → tag0 written back at cycle 6, tag1 at cycle 7; no write-back before cycle 6.
- LSU tag0 err=1, `longp_excp_o_ready` = 0 for 3 cycles → `longp_excp_o_valid` held 3 cycles, `longp_wbck_o_valid` = 0, `oitf_ret_ena` only on the ready cycle.
- `longp_wbck_o_ready` = 0 with both slots full → both input readies = 0, payload stable; ready rises → one retire per cycle for 2 cycles.
- rdwen=0 entry (e.g. store) at head → `oitf_ret_ena` pulse with `longp_wbck_o_valid` = 0 and `longp_excp_o_valid` = 0.
- `rst_n` pulled low while slot1 is valid and stalled → outputs go to 0 immediately; after release, no stale write-back appears.
